// File: rtl/instr_encoder_loader.sv
// Symbolic instruction request to MIPS machine word encoder.
// Streams encoded words into IM from BASE, one load session at a time.
module instr_encoder_loader #(
  parameter logic [31:0] BASE  = 32'h0000_3000,
  parameter int          DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [25:0] in_imm,
  input  logic        in_last,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [10:0] count
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t      state;
  logic        legal;
  logic        at_depth;
  logic [31:0] enc;
  logic [15:0] imm16;

  assign imm16    = in_imm[15:0];
  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign at_depth = (count == 11'(DEPTH - 1));

  // Fields not used by a format are never taken from the inputs.
  always_comb begin
    enc   = 32'h0;
    legal = 1'b1;
    unique case (1'b1)
      (in_op == 5'd0):
        enc = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h21};
      (in_op == 5'd1):
        enc = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h23};
      (in_op == 5'd2):
        enc = {6'h00, 5'd0, in_rt, in_rd, in_shamt, 6'h00};
      (in_op == 5'd3):
        enc = {6'h00, in_rs, 15'd0, 6'h08};
      (in_op == 5'd4):
        enc = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h24};
      (in_op == 5'd5):
        enc = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2A};
      (in_op == 5'd6):
        enc = {6'h00, in_rs, 5'd0, in_rd, 5'd0, 6'h09};
      (in_op == 5'd7):
        enc = {6'h0D, in_rs, in_rt, imm16};
      (in_op == 5'd8):
        enc = {6'h0F, 5'd0, in_rt, imm16};
      (in_op == 5'd9):
        enc = {6'h09, in_rs, in_rt, imm16};
      (in_op == 5'd10):
        enc = {6'h04, in_rs, in_rt, imm16};
      (in_op == 5'd11):
        enc = {6'h2B, in_rs, in_rt, imm16};
      (in_op == 5'd12):
        enc = {6'h29, in_rs, in_rt, imm16};
      (in_op == 5'd13):
        enc = {6'h28, in_rs, in_rt, imm16};
      (in_op == 5'd14):
        enc = {6'h23, in_rs, in_rt, imm16};
      (in_op == 5'd15):
        enc = {6'h21, in_rs, in_rt, imm16};
      (in_op == 5'd16):
        enc = {6'h20, in_rs, in_rt, imm16};
      (in_op == 5'd17):
        enc = {6'h02, in_imm};
      (in_op == 5'd18):
        enc = {6'h03, in_imm};
      default:
        legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      im_we    <= 1'b0;
      im_addr  <= 32'h0;
      im_wdata <= 32'h0;
      count    <= 11'd0;
      err      <= 1'b0;
    end else begin
      im_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            count <= 11'd0;
            err   <= 1'b0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (legal) begin
              im_we    <= 1'b1;
              im_addr  <= BASE + {19'd0, count, 2'b00};
              im_wdata <= enc;
              count    <= count + 11'd1;
              if (at_depth && !in_last)
                err <= 1'b1;
            end else begin
              err <= 1'b1;
            end
            if (in_last || (legal && at_depth))
              state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
